// File: rtl/messbauer_channel_sequencer_pkg.sv
// Shared types and defaults for the Mossbauer channel sequencer.
package messbauer_channel_sequencer_pkg;

  // Sequencer phases; one measurement channel walks GenReq -> GenWait -> Pause -> ChannelPulse.
  typedef enum logic [2:0] {
    StIdle,
    StFrameStart,
    StGenReq,
    StGenWait,
    StPause,
    StChannelPulse,
    StDone
  } state_e;

  localparam int unsigned DefChannelsNumber = 512;
  localparam int unsigned DefChannelWidth   = 9;
  localparam int unsigned DefCounterWidth   = 16;
  localparam int unsigned DefStartDuration  = 2;
  localparam int unsigned DefChannelDuration = 2;
  localparam int unsigned DefChannelPause   = 4;
  localparam int unsigned DefGenTimeout     = 255;

  // Width needed to hold (longest phase length - 1), never less than one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/messbauer_phase_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// A load of N gives N+1 cycles before expired_o is seen high.
module messbauer_phase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             aclk_i,
  input  logic             areset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/messbauer_channel_sequencer.sv
// Steps a Mossbauer spectrometer through its velocity channels: frame start, generator
// handshake, pause, then a channel-advance pulse, repeated for a finite or endless run.
module messbauer_channel_sequencer
  import messbauer_channel_sequencer_pkg::*;
#(
  parameter int unsigned CHANNELS_NUMBER  = DefChannelsNumber,
  parameter int unsigned CHANNEL_WIDTH    = DefChannelWidth,
  parameter int unsigned COUNTER_WIDTH    = DefCounterWidth,
  parameter int unsigned START_DURATION   = DefStartDuration,
  parameter int unsigned CHANNEL_DURATION = DefChannelDuration,
  parameter int unsigned CHANNEL_PAUSE    = DefChannelPause,
  parameter int unsigned GEN_TIMEOUT      = DefGenTimeout
) (
  input  logic                     aclk_i,
  input  logic                     areset_i,
  input  logic                     enable_i,
  input  logic [COUNTER_WIDTH-1:0] cfg_cycles_i,
  output logic                     gen_start_o,
  input  logic                     gen_done_i,
  output logic                     start_o,
  output logic                     channel_o,
  output logic [CHANNEL_WIDTH-1:0] channel_index_o,
  output logic [COUNTER_WIDTH-1:0] cycle_count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_error_o
);

  localparam int unsigned TimerWidth =
      timer_width(START_DURATION, CHANNEL_DURATION, CHANNEL_PAUSE, GEN_TIMEOUT);
  localparam logic [CHANNEL_WIDTH-1:0] LastChannel = CHANNEL_WIDTH'(CHANNELS_NUMBER - 1);
  localparam logic [COUNTER_WIDTH-1:0] CountOne    = COUNTER_WIDTH'(1);

  state_e                   state_q, state_d;
  logic                     enable_q;  // enable delayed by one cycle, for edge detection
  logic                     armed_q;   // a level held across reset release is not an edge
  logic [COUNTER_WIDTH-1:0] cycles_target_q;
  logic [COUNTER_WIDTH-1:0] cycle_count_q;
  logic [COUNTER_WIDTH-1:0] count_inc;
  logic [CHANNEL_WIDTH-1:0] channel_index_q;
  logic                     start_q, gen_start_q, channel_q, busy_q, done_q, timeout_error_q;

  logic                  timer_load;
  logic [TimerWidth-1:0] timer_value;
  logic                  timer_expired;

  logic start_run, gen_timeout, channel_end, last_channel, target_hit;

  assign count_inc    = cycle_count_q + CountOne;
  assign last_channel = (channel_index_q == LastChannel);
  assign target_hit   = (cycles_target_q != '0) && (count_inc == cycles_target_q);
  assign channel_end  = (state_q == StChannelPulse) && timer_expired;

  // Next-phase decision; enable is only consulted at channel boundaries.
  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    gen_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && !enable_q && armed_q) begin
          start_run = 1'b1;
          state_d   = StFrameStart;
        end
      end
      StFrameStart: if (timer_expired) state_d = StGenReq;
      StGenReq:     state_d = StGenWait;
      StGenWait: begin
        // A completion in the timeout cycle still counts as a completion.
        if (gen_done_i) begin
          state_d = StPause;
        end else if (timer_expired) begin
          state_d     = StPause;
          gen_timeout = 1'b1;
        end
      end
      StPause: if (timer_expired) state_d = StChannelPulse;
      StChannelPulse: begin
        if (timer_expired) begin
          if (!last_channel)   state_d = enable_i ? StGenReq : StIdle;
          else if (target_hit) state_d = StDone;
          else                 state_d = enable_i ? StFrameStart : StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reload the shared timer with the length of whichever phase is being entered.
  always_comb begin
    timer_load  = (state_d != state_q);
    timer_value = '0;
    unique case (state_d)
      StFrameStart:   timer_value = TimerWidth'(START_DURATION - 1);
      StGenWait:      timer_value = TimerWidth'(GEN_TIMEOUT - 1);
      StPause:        timer_value = TimerWidth'(CHANNEL_PAUSE - 1);
      StChannelPulse: timer_value = TimerWidth'(CHANNEL_DURATION - 1);
      default:        timer_value = '0;
    endcase
  end

  messbauer_phase_timer #(
    .Width(TimerWidth)
  ) u_phase_timer (
    .aclk_i      (aclk_i),
    .areset_i    (areset_i),
    .load_i      (timer_load),
    .load_value_i(timer_value),
    .expired_o   (timer_expired)
  );

  // Phase register, run bookkeeping and registered outputs decoded from the next phase.
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q         <= StIdle;
      enable_q        <= 1'b0;
      armed_q         <= 1'b0;
      cycles_target_q <= '0;
      cycle_count_q   <= '0;
      channel_index_q <= '0;
      start_q         <= 1'b0;
      gen_start_q     <= 1'b0;
      channel_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_i;
      if (!enable_i) armed_q <= 1'b1;
      start_q     <= (state_d == StFrameStart);
      gen_start_q <= (state_d == StGenReq);
      channel_q   <= (state_d == StChannelPulse);
      done_q      <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
      if (start_run) begin
        cycles_target_q <= cfg_cycles_i;
        cycle_count_q   <= '0;
        channel_index_q <= '0;
        timeout_error_q <= 1'b0;
      end
      if (gen_timeout) timeout_error_q <= 1'b1;
      if (channel_end) begin
        if (last_channel) begin
          channel_index_q <= '0;
          if (cycle_count_q != '1) cycle_count_q <= count_inc;
        end else begin
          channel_index_q <= channel_index_q + CHANNEL_WIDTH'(1);
        end
      end
    end
  end

  assign start_o         = start_q;
  assign gen_start_o     = gen_start_q;
  assign channel_o       = channel_q;
  assign channel_index_o = channel_index_q;
  assign cycle_count_o   = cycle_count_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_error_o = timeout_error_q;

endmodule

// File: tb/tb_messbauer_channel_sequencer.sv
// Randomized bench: a timeline model builds per-cycle stimulus and expected outputs for
// each run from the sequencing rules, then the DUT is stepped and compared cycle by cycle.
module tb_messbauer_channel_sequencer;

  localparam int unsigned NCh      = 4;
  localparam int unsigned ChW      = 2;
  localparam int unsigned CntW     = 2;
  localparam int unsigned StartDur = 2;
  localparam int unsigned ChanDur  = 2;
  localparam int unsigned PauseLen = 3;
  localparam int unsigned Tmo      = 8;

  typedef struct packed {
    logic            start;
    logic            gen_start;
    logic            channel;
    logic            busy;
    logic            done;
    logic            terr;
    logic [ChW-1:0]  idx;
    logic [CntW-1:0] cnt;
  } obs_t;

  logic            aclk, areset, enable, gen_done;
  logic [CntW-1:0] cfg_cycles;
  logic            gen_start_o, start_o, channel_o, busy_o, done_o, timeout_error_o;
  logic [ChW-1:0]  channel_index_o;
  logic [CntW-1:0] cycle_count_o;

  int checks, failures;
  obs_t exp_q[$];
  bit   en_q[$];
  bit   gd_q[$];
  int   m_idx, m_cnt;
  bit   m_terr;

  messbauer_channel_sequencer #(
    .CHANNELS_NUMBER (NCh),
    .CHANNEL_WIDTH   (ChW),
    .COUNTER_WIDTH   (CntW),
    .START_DURATION  (StartDur),
    .CHANNEL_DURATION(ChanDur),
    .CHANNEL_PAUSE   (PauseLen),
    .GEN_TIMEOUT     (Tmo)
  ) dut (
    .aclk_i         (aclk),
    .areset_i       (areset),
    .enable_i       (enable),
    .cfg_cycles_i   (cfg_cycles),
    .gen_start_o    (gen_start_o),
    .gen_done_i     (gen_done),
    .start_o        (start_o),
    .channel_o      (channel_o),
    .channel_index_o(channel_index_o),
    .cycle_count_o  (cycle_count_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_error_o(timeout_error_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {start_o, gen_start_o, channel_o, busy_o, done_o, timeout_error_o,
         channel_index_o, cycle_count_o};
    return o;
  endfunction

  // Random stray completion, for cycles where the DUT must ignore gen_done.
  function automatic bit spur();
    return ($urandom_range(3) == 0);
  endfunction

  task automatic add(input bit st, input bit gs, input bit chn, input bit dn, input bit bsy,
                     input bit en, input bit gd);
    obs_t o;
    o.start     = st;
    o.gen_start = gs;
    o.channel   = chn;
    o.busy      = bsy;
    o.done      = dn;
    o.terr      = m_terr;
    o.idx       = ChW'(m_idx);
    o.cnt       = CntW'(m_cnt);
    exp_q.push_back(o);
    en_q.push_back(en);
    gd_q.push_back(gd);
  endtask

  // Timeline of one run. Latency L counts cycles from gen_start to gen_done; L > Tmo never
  // lands in the wait window. stop_k is the channel ordinal whose wait sees enable fall.
  task automatic build_run(input int cfg, input int stop_k, input int lat_fixed,
                           input int force_k, input int force_lat);
    int  k, lat, w;
    bit  en, running;
    en = 1'b1;
    running = 1'b1;
    k = 0;
    add(0, 0, 0, 0, 0, en, spur());
    m_idx = 0; m_cnt = 0; m_terr = 1'b0;
    while (running) begin
      repeat (StartDur) add(1, 0, 0, 0, 1, en, spur());
      for (int ch = 0; ch < int'(NCh); ch++) begin
        if (k == force_k)     lat = force_lat;
        else if (lat_fixed > 0) lat = lat_fixed;
        else                  lat = int'($urandom_range(1, Tmo + 3));
        add(0, 1, 0, 0, 1, en, spur());
        if (k == stop_k) en = 1'b0;
        w = (lat <= int'(Tmo)) ? lat : int'(Tmo);
        for (int i = 1; i <= w; i++) add(0, 0, 0, 0, 1, en, (i == lat));
        if (lat > int'(Tmo)) m_terr = 1'b1;
        for (int p = 1; p <= int'(PauseLen); p++)
          add(0, 0, 0, 0, 1, en, (lat == int'(Tmo) + p) ? 1'b1 : spur());
        repeat (ChanDur) add(0, 0, 1, 0, 1, en, spur());
        k++;
        if (ch != int'(NCh) - 1) begin
          m_idx++;
          if (!en) begin
            running = 1'b0;
            break;
          end
        end else begin
          m_idx = 0;
          if (m_cnt < (1 << CntW) - 1) m_cnt++;
          if (cfg != 0 && m_cnt == cfg) begin
            add(0, 0, 0, 1, 1, en, spur());
            running = 1'b0;
          end else if (!en) begin
            running = 1'b0;
          end
        end
      end
    end
    // Idle tail: enable still held for a while must not restart, then drop it.
    repeat (3) add(0, 0, 0, 0, 0, en, spur());
    repeat (2) add(0, 0, 0, 0, 0, 1'b0, spur());
  endtask

  task automatic run_plan(input string name, input int cfg);
    cfg_cycles = CntW'(cfg);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge aclk);
      enable   = en_q[i];
      gen_done = gd_q[i];
      check_eq($sformatf("%s c%0d", name, i), 32'(sample()), 32'(exp_q[i]));
    end
    exp_q.delete();
    en_q.delete();
    gd_q.delete();
  endtask

  initial begin
    int  cfg, stop_k;
    bit  found;
    checks = 0; failures = 0;
    m_idx = 0; m_cnt = 0; m_terr = 1'b0;
    areset = 1'b1; enable = 1'b0; gen_done = 1'b0; cfg_cycles = '0;
    repeat (2) @(negedge aclk);
    check_eq("reset_state", 32'(sample()), 32'(0));
    areset = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      check_eq("idle_after_reset", 32'(sample()), 32'(0));
    end

    build_run(2, -1, 3, -1, 0);
    run_plan("finite", 2);
    build_run(1, -1, 3, 1, int'(Tmo) + 2);
    run_plan("timeout", 1);
    build_run(0, 2, 3, -1, 0);
    run_plan("stop", 0);
    build_run(1, -1, int'(Tmo), -1, 0);
    run_plan("collide", 1);
    for (int r = 0; r < 8; r++) begin
      cfg = int'($urandom_range(0, 3));
      if (cfg == 0)                 stop_k = int'($urandom_range(0, 5 * NCh - 1));
      else if ($urandom_range(1) == 0) stop_k = -1;
      else                          stop_k = int'($urandom_range(0, NCh * cfg - 1));
      build_run(cfg, stop_k, 0, -1, 0);
      run_plan($sformatf("rand%0d", r), cfg);
    end

    // Reset in the middle of a channel pulse.
    cfg_cycles = '0;
    gen_done = 1'b0;
    @(negedge aclk);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge aclk);
      if (channel_o && channel_index_o == ChW'(2)) found = 1'b1;
    end
    check_eq("rst_reach_pulse", 32'(found), 32'(1));
    areset = 1'b1;
    #1;
    check_eq("rst_async", 32'(sample()), 32'(0));
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check_eq($sformatf("rst_hold c%0d", i), 32'({busy_o, start_o}), 32'(0));
    end
    enable = 1'b0;
    @(negedge aclk);
    enable = 1'b1;
    @(negedge aclk);
    check_eq("rst_restart", 32'({start_o, busy_o, gen_start_o}), 32'(3'b110));
    areset = 1'b1;
    enable = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check_eq("final_idle", 32'(sample()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
